bridge_response_tx: RTL
=======================

// Module: bridge_response_tx
//
// PURPOSE
// Host-bound end of the UART debug bridge. Takes a 16-bit register read
// result from the core bus and frames it as the ASCII response "Mxxxx\r\n"
// (x = 4 uppercase hex digits, MSB nibble first). Serializes that response
// as 8N1 UART on the tx pin. Pairs with the request parser on the rx pin, so
// the host sees one response line per read request.
//
// PARAMETERS
// CLOCKS_PER_BAUD  868  clk cycles per UART bit (100 MHz / 115200); legal >= 2
//
// PORTS
// clk      input   1   system clock; all logic on posedge
// rst_n    input   1   asynchronous, active-low reset
// data_i   input   16  read data to report; sampled only on accept
// valid_i  input   1   data_i holds a response to send
// ready_o  output  1   block idle, can accept a response
// busy_o   output  1   message in flight (== ~ready_o)
// tx       output  1   UART serial out, idle high
//
// BEHAVIOUR
// - Reset (async assert, synchronous release):
//   tx=1, ready_o=1, busy_o=0, all counters=0, state=IDLE.
// - Handshake: accept on a posedge where valid_i && ready_o.
//   - data_i is latched into a 16-bit holding register on that edge.
//   - Later changes on data_i/valid_i are ignored until the block is idle again.
// - ready_o is decoded from state==IDLE (no extra register).
// - Message: 7 bytes, in order:
//   'M'(0x4D), hex(d[15:12]), hex(d[11:8]), hex(d[7:4]), hex(d[3:0]),
//   0x0D, 0x0A.
//   - hex(n) = 0x30+n for n<=9, else 0x41+n-10 (uppercase).
// - Frame per byte: start(0), 8 data bits LSB first, stop(1).
//   Each bit holds exactly CLOCKS_PER_BAUD cycles.
// - Bytes are sent back-to-back, with no idle gap between stop bit and next start bit.
// - FSM:
//   - IDLE: tx=1; on accept -> SEND, byte_idx=0, bit_idx=0, baud_cnt=0.
//     tx goes low (start bit) on the accept edge.
//   - SEND: baud_cnt counts 0..CLOCKS_PER_BAUD-1.
//     - On wrap, bit_idx advances 0..9.
//     - On bit_idx 9 wrap, byte_idx advances 0..6.
//     - On the wrap of byte 6 stop bit -> IDLE.
// - tx is registered, so it never glitches between bits.
// - Latency: start bit of 'M' visible the cycle after the accept edge.
//   The line returns high/idle 70*CLOCKS_PER_BAUD cycles after the accept edge.
// - Throughput: with valid_i held high, consecutive accepts are
//   70*CLOCKS_PER_BAUD+1 cycles apart (one idle-high cycle between messages).
// - Counter widths: baud_cnt = $clog2(CLOCKS_PER_BAUD), bit_idx = 4 bits,
//   byte_idx = 3 bits. None is allowed to exceed its terminal value.
// - Reset mid-message:
//   - tx forced to 1 immediately; ready_o=1.
//   - The partial message is dropped and never resumed.
// - valid_i with ready_o=0: no effect, no queuing. The upstream holds valid_i
//   until accepted.
// - valid_i during the reset-release cycle: accepted normally on the first
//   edge with rst_n=1.
//
// TESTING (bench with CLOCKS_PER_BAUD=4; sample tx mid-bit)
// - Reset, then data_i=16'h1234 valid pulse
//   -> bytes 4D 31 32 33 34 0D 0A, ready_o low 280 cycles, tx high after.
// - data_i=16'hABCF -> bytes 4D 41 42 43 46 0D 0A (uppercase, 9/A boundary via 16'h09A0 -> 30 39 41 30).
// - valid_i held high, data 16'h0000 then 16'hFFFF
//   -> second start bit exactly 281 cycles after first; second payload 46 46 46 46.
// - Change data_i and pulse valid_i during transmission
//   -> transmitted bytes unchanged, no second message queued.
// - Assert rst_n=0 during byte 2 bit 5
//   -> tx=1 same cycle, ready_o=1. After release, new 16'h00FF sends a clean full message.
// - Bit timing check: every tx level persists a multiple of 4 cycles.
//   Total low/high pattern matches the reference 8N1 model for 1000 random words.

Source files
------------

// File: rtl/bridge_response_tx.sv
// ---------------------------------------------------------------------------
// bridge_response_tx
//
// Host-bound end of the UART debug bridge. A 16-bit register read result is
// accepted from the core bus and framed as the ASCII line "Mxxxx\r\n", where
// xxxx is four uppercase hex digits, most significant nibble first. The seven
// bytes are sent back-to-back as 8N1 UART on the tx pin.
//
// Ports
//   clk      in   1   system clock, all logic on posedge
//   rst_n    in   1   asynchronous active-low reset, synchronous release
//   data_i   in   16  read data to report, sampled only on accept
//   valid_i  in   1   data_i holds a response to send
//   ready_o  out  1   idle, a response can be accepted this cycle
//   busy_o   out  1   message in flight (always ~ready_o)
//   tx       out  1   UART serial out, idle high, registered
//
// Parameter
//   CLOCKS_PER_BAUD   clk cycles per UART bit, must be at least 2
// ---------------------------------------------------------------------------
module bridge_response_tx #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        tx
);

    // Counter geometry. The baud counter is just wide enough for its terminal
    // value; bit and byte indices cover 0..9 and 0..6.
    localparam int BAUD_W = (CLOCKS_PER_BAUD > 2) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [3:0]        BIT_LAST  = 4'd9;
    localparam logic [2:0]        BYTE_LAST = 3'd6;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q;
    logic [BAUD_W-1:0]  baudCnt_q;
    logic [3:0]         bitIdx_q;
    logic [2:0]         byteIdx_q;
    logic [15:0]        holdData_q;
    logic               tx_q;

    logic               bitWrap;
    logic               frameWrap;
    logic               msgDone;
    logic [BAUD_W-1:0]  baudCnt_d;
    logic [3:0]         bitIdx_d;
    logic [2:0]         byteIdx_d;
    logic [7:0]         nextByte;
    logic               nextLine;
    logic               accept;

    // Nibble to uppercase ASCII hex: '0'..'9' then 'A'..'F'.
    function automatic logic [7:0] hexAscii(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib <= 4'd9) begin
            return 8'h30 + wide;
        end
        return 8'h37 + wide;
    endfunction

    // Byte at a given position of the "Mxxxx\r\n" message.
    function automatic logic [7:0] msgByte(input logic [2:0] idx, input logic [15:0] d);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h4D;
            3'd1:    b = hexAscii(d[15:12]);
            3'd2:    b = hexAscii(d[11:8]);
            3'd3:    b = hexAscii(d[7:4]);
            3'd4:    b = hexAscii(d[3:0]);
            3'd5:    b = 8'h0D;
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    // Line level for one slot of an 8N1 frame: slot 0 is the start bit,
    // slots 1..8 carry data LSB first, slot 9 is the stop bit.
    function automatic logic frameBit(input logic [7:0] b, input logic [3:0] slot);
        logic v;
        case (slot)
            4'd0:    v = 1'b0;
            4'd1:    v = b[0];
            4'd2:    v = b[1];
            4'd3:    v = b[2];
            4'd4:    v = b[3];
            4'd5:    v = b[4];
            4'd6:    v = b[5];
            4'd7:    v = b[6];
            4'd8:    v = b[7];
            default: v = 1'b1;
        endcase
        return v;
    endfunction

    // Handshake decode: ready is purely the IDLE state, no extra register.
    assign ready_o = (state_q == IDLE);
    assign busy_o  = ~ready_o;
    assign accept  = valid_i && ready_o;
    assign tx      = tx_q;

    // Next position within the message. The line level for the next bit is
    // looked up one cycle ahead so tx can be registered and change exactly on
    // the bit boundary.
    always_comb begin
        bitWrap   = (baudCnt_q == BAUD_LAST);
        frameWrap = bitWrap && (bitIdx_q == BIT_LAST);
        msgDone   = frameWrap && (byteIdx_q == BYTE_LAST);

        baudCnt_d = bitWrap ? '0 : baudCnt_q + BAUD_W'(1);

        bitIdx_d = bitIdx_q;
        if (bitWrap) begin
            bitIdx_d = (bitIdx_q == BIT_LAST) ? 4'd0 : bitIdx_q + 4'd1;
        end

        byteIdx_d = byteIdx_q;
        if (frameWrap) begin
            byteIdx_d = (byteIdx_q == BYTE_LAST) ? 3'd0 : byteIdx_q + 3'd1;
        end

        nextByte = msgByte(byteIdx_d, holdData_q);
        nextLine = frameBit(nextByte, bitIdx_d);
    end

    // Transmit FSM. IDLE holds the line high and waits for a handshake; the
    // start bit of 'M' is driven on the accept edge itself. SEND walks the
    // baud, bit and byte counters and falls back to IDLE as the stop bit of
    // the last byte expires, which leaves one idle-high cycle before the next
    // accept can happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= 4'd0;
            byteIdx_q  <= 3'd0;
            holdData_q <= 16'h0000;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (accept) begin
                        holdData_q <= data_i;
                        baudCnt_q  <= '0;
                        bitIdx_q   <= 4'd0;
                        byteIdx_q  <= 3'd0;
                        tx_q       <= 1'b0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    baudCnt_q <= baudCnt_d;
                    bitIdx_q  <= bitIdx_d;
                    byteIdx_q <= byteIdx_d;
                    if (msgDone) begin
                        tx_q    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tx_q <= nextLine;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Counters must never pass their terminal values.
    a_baudBound: assert property (@(posedge clk) disable iff (!rst_n)
        baudCnt_q <= BAUD_LAST);
    a_bitBound: assert property (@(posedge clk) disable iff (!rst_n)
        bitIdx_q <= BIT_LAST);
    a_byteBound: assert property (@(posedge clk) disable iff (!rst_n)
        byteIdx_q <= BYTE_LAST);

endmodule
